// File: rtl/gpio_slave_if.sv
// Bus-side register port of the GPIO slave.
// The master drives address/strobe/data, the slave returns read data.
interface gpio_slave_if;
  logic [31:0] addr_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (
    output addr_i,
    output we_i,
    output wdata_i,
    input  rdata_o
  );

  modport slave (
    input  addr_i,
    input  we_i,
    input  wdata_i,
    output rdata_o
  );
endinterface

// File: rtl/gpio_slave.sv
// Memory-mapped GPIO: direction/output regs, synchronized inputs,
// per-pin edge detection with sticky status and level interrupt.
module gpio_slave #(
  parameter int GPIO_NUM    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  gpio_slave_if.slave         bus,
  input  logic [GPIO_NUM-1:0] gpio_i,
  output logic [GPIO_NUM-1:0] gpio_o,
  output logic [GPIO_NUM-1:0] gpio_oe_o,
  output logic                irq_o
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int CW      = $clog2(ARM_MAX + 1);

  typedef logic [GPIO_NUM-1:0] pins_t;

  pins_t dir_q;
  pins_t out_q;
  pins_t ie_q;
  pins_t edge_q;
  pins_t is_q;
  pins_t is_d;
  pins_t hist_q;
  pins_t synced;
  pins_t rise;
  pins_t fall;
  pins_t det;
  pins_t wd;
  pins_t clr;

  logic [SYNC_STAGES-1:0][GPIO_NUM-1:0] sync_q;

  logic [CW-1:0] arm_q;
  logic          armed;

  logic [7:0] sel;
  logic       wr_dir;
  logic       wr_out;
  logic       wr_ie;
  logic       wr_edge;
  logic       wr_is;
  logic [31:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^{bus.addr_i[31:5],
                         bus.addr_i[1:0],
                         bus.wdata_i};

  always_comb begin
    sel = 8'b0;
    sel[bus.addr_i[4:2]] = 1'b1;
  end

  assign wd      = bus.wdata_i[GPIO_NUM-1:0];
  assign wr_dir  = bus.we_i & sel[0];
  assign wr_out  = bus.we_i & sel[1];
  assign wr_ie   = bus.we_i & sel[3];
  assign wr_edge = bus.we_i & sel[4];
  assign wr_is   = bus.we_i & sel[5];

  assign synced = sync_q[SYNC_STAGES-1];
  assign armed  = (arm_q == CW'(ARM_MAX));

  assign rise = synced & ~hist_q;
  assign fall = ~synced & hist_q;

  // Until the synchronizer and history have been refilled
  // from the pads, their reset zeros would look like edges.
  always_comb begin
    det = '0;
    if (armed)
      det = (edge_q & rise) | (~edge_q & fall);
  end

  // A fresh edge outranks a simultaneous write-1-to-clear.
  always_comb begin
    clr  = wr_is ? wd : '0;
    is_d = (is_q & ~clr) | det;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q  <= '0;
      out_q  <= '0;
      ie_q   <= '0;
      edge_q <= '0;
      is_q   <= '0;
    end else begin
      if (wr_dir)
        dir_q <= wd;
      if (wr_out)
        out_q <= wd;
      if (wr_ie)
        ie_q <= wd;
      if (wr_edge)
        edge_q <= wd;
      is_q <= is_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
      hist_q <= synced;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      arm_q <= '0;
    else if (!armed)
      arm_q <= arm_q + CW'(1);
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel[0]: rdata[GPIO_NUM-1:0] = dir_q;
      sel[1]: rdata[GPIO_NUM-1:0] = out_q;
      sel[2]: rdata[GPIO_NUM-1:0] = synced;
      sel[3]: rdata[GPIO_NUM-1:0] = ie_q;
      sel[4]: rdata[GPIO_NUM-1:0] = edge_q;
      sel[5]: rdata[GPIO_NUM-1:0] = is_q;
      sel[6],
      sel[7]: rdata = '0;
    endcase
  end

  assign bus.rdata_o = rdata;
  assign gpio_o      = out_q;
  assign gpio_oe_o   = dir_q;
  assign irq_o       = |(is_q & ie_q);

endmodule

// File: tb/tb_gpio_slave.sv
// Scenario bench for gpio_slave: expected values are queued as
// stimulus is applied and popped when the DUT result is sampled.
module tb_gpio_slave;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] gpio_i = '0;
  logic [N-1:0] gpio_o;
  logic [N-1:0] gpio_oe_o;
  logic         irq_o;

  gpio_slave_if bus ();

  gpio_slave #(
    .GPIO_NUM    (N),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .gpio_i    (gpio_i),
    .gpio_o    (gpio_o),
    .gpio_oe_o (gpio_oe_o),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got;
  logic [31:0] e;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] off,
                    input logic [31:0] d);
    @(negedge clk);
    bus.addr_i  = {27'd0, off, 2'b00};
    bus.wdata_i = d;
    bus.we_i    = 1'b1;
    @(negedge clk);
    bus.we_i    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] off,
                    output logic [31:0] d);
    bus.addr_i = {27'd0, off, 2'b00};
    #1;
    d = bus.rdata_o;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc(2);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    got = {16'h0, gpio_oe_o};
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL rst_oe got=%h want=%h", got, e);
    end
    got = {16'h0, gpio_o};
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL rst_out got=%h want=%h", got, e);
    end
    got = {31'h0, irq_o};
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL rst_irq got=%h want=%h", got, e);
    end
    rst = 1'b1;
    for (int i = 0; i < 8; i++)
      exp_q.push_back(32'h0);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), got);
      e = exp_q.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL rst_rd%0d got=%h want=%h", i, got, e);
      end
    end
  endtask

  task automatic test_readback();
    wr(3'd0, 32'h0000_00FF);
    wr(3'd1, 32'h0000_A5A5);
    exp_q.push_back(32'h0000_00FF);
    exp_q.push_back(32'h0000_A5A5);
    exp_q.push_back(32'h0000_00FF);
    exp_q.push_back(32'h0000_A5A5);
    got = {16'h0, gpio_oe_o};
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL oe_pins got=%h want=%h", got, e);
    end
    got = {16'h0, gpio_o};
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL out_pins got=%h want=%h", got, e);
    end
    rd(3'd0, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL dir_rd got=%h want=%h", got, e);
    end
    rd(3'd1, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL out_rd got=%h want=%h", got, e);
    end
    wr(3'd2, 32'h0000_FFFF);
    exp_q.push_back(32'h0);
    rd(3'd2, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL in_ro got=%h want=%h", got, e);
    end
  endtask

  task automatic test_sync();
    cyc(4);
    gpio_i = 16'h0003;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h3);
    for (int c = 0; c < 3; c++) begin
      rd(3'd2, got);
      e = exp_q.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL sync_c%0d got=%h want=%h", c, got, e);
      end
      cyc(1);
    end
    gpio_i = '0;
    cyc(4);
    wr(3'd5, 32'h0000_FFFF);
    exp_q.push_back(32'h0);
    rd(3'd5, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL is_clr got=%h want=%h", got, e);
    end
  endtask

  task automatic test_rise_irq();
    wr(3'd3, 32'h1);
    wr(3'd4, 32'h1);
    gpio_i[0] = 1'b1;
    cyc(2);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    rd(3'd5, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL rise_early got=%h want=%h", got, e);
    end
    got = {31'h0, irq_o};
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL irq_early got=%h want=%h", got, e);
    end
    cyc(1);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    rd(3'd5, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL rise_is got=%h want=%h", got, e);
    end
    got = {31'h0, irq_o};
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL rise_irq got=%h want=%h", got, e);
    end
    gpio_i[0] = 1'b0;
    wr(3'd5, 32'h1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    rd(3'd5, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL w1c_is got=%h want=%h", got, e);
    end
    got = {31'h0, irq_o};
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL w1c_irq got=%h want=%h", got, e);
    end
    cyc(4);
    exp_q.push_back(32'h0);
    rd(3'd5, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL fall_ign got=%h want=%h", got, e);
    end
  endtask

  task automatic test_set_wins();
    wr(3'd3, 32'h8);
    wr(3'd4, 32'h8);
    gpio_i[3] = 1'b1;
    cyc(3);
    gpio_i[3] = 1'b0;
    cyc(4);
    exp_q.push_back(32'h8);
    rd(3'd5, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL sw_pre got=%h want=%h", got, e);
    end
    gpio_i[3] = 1'b1;
    cyc(2);
    bus.addr_i  = {27'd0, 3'd5, 2'b00};
    bus.wdata_i = 32'h8;
    bus.we_i    = 1'b1;
    cyc(1);
    bus.we_i    = 1'b0;
    exp_q.push_back(32'h8);
    exp_q.push_back(32'h1);
    rd(3'd5, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL sw_is got=%h want=%h", got, e);
    end
    got = {31'h0, irq_o};
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL sw_irq got=%h want=%h", got, e);
    end
    wr(3'd5, 32'h8);
    exp_q.push_back(32'h0);
    got = {31'h0, irq_o};
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL sw_clr got=%h want=%h", got, e);
    end
  endtask

  task automatic test_arming();
    gpio_i = 16'hFFFF;
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    wr(3'd3, 32'h0000_FFFF);
    cyc(6);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    rd(3'd5, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL arm_f_is got=%h want=%h", got, e);
    end
    got = {31'h0, irq_o};
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL arm_f_irq got=%h want=%h", got, e);
    end
    gpio_i[5] = 1'b0;
    cyc(3);
    exp_q.push_back(32'h20);
    exp_q.push_back(32'h1);
    rd(3'd5, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL arm_fall got=%h want=%h", got, e);
    end
    got = {31'h0, irq_o};
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL arm_irq got=%h want=%h", got, e);
    end
    gpio_i = 16'hFFFF;
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    wr(3'd4, 32'h0000_FFFF);
    wr(3'd3, 32'h0000_FFFF);
    cyc(6);
    exp_q.push_back(32'h0);
    rd(3'd5, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL arm_r_is got=%h want=%h", got, e);
    end
    gpio_i[7] = 1'b0;
    cyc(4);
    gpio_i[7] = 1'b1;
    cyc(3);
    exp_q.push_back(32'h80);
    rd(3'd5, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL arm_rise got=%h want=%h", got, e);
    end
  endtask

  task automatic test_width();
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd6, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_FFFF);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    rd(3'd0, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL dir_wide got=%h want=%h", got, e);
    end
    rd(3'd6, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL off6 got=%h want=%h", got, e);
    end
    rd(3'd7, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL off7 got=%h want=%h", got, e);
    end
  endtask

  task automatic test_reset_mid_write();
    wr(3'd1, 32'h0000_5A5A);
    bus.addr_i  = {27'd0, 3'd1, 2'b00};
    bus.wdata_i = 32'h0000_1234;
    bus.we_i    = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    got = {16'h0, gpio_o};
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL mid_pins got=%h want=%h", got, e);
    end
    rd(3'd0, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL mid_dir got=%h want=%h", got, e);
    end
    bus.addr_i = {27'd0, 3'd1, 2'b00};
    cyc(1);
    rst = 1'b1;
    bus.we_i = 1'b0;
    exp_q.push_back(32'h0);
    rd(3'd1, got);
    e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL mid_out got=%h want=%h", got, e);
    end
  endtask

  initial begin
    bus.addr_i  = '0;
    bus.we_i    = 1'b0;
    bus.wdata_i = '0;
    test_reset();
    test_readback();
    test_sync();
    test_rise_irq();
    test_set_wins();
    test_arming();
    test_width();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
